dm_cache_ctrl: RTL and testbench



---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_line_array.sv | 79 +++++++
 rtl/dm_cache_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache controller: FSM encoding,
// line geometry and address-field width helpers.
package cache_pkg;

  localparam int OFFSET_BITS = 2;
  localparam int LINE_WORDS  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } cache_state_e;

  function automatic int index_width(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_width(input int word_size, input int num_lines);
    return word_size - OFFSET_BITS - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Per-line valid/dirty/tag/data storage with a combinational read port,
// a single-word write port (marks dirty), a whole-line fill port and a dirty-clear port.
module cache_line_array
  import cache_pkg::*;
#(
  parameter  int WORD_SIZE = 16,
  parameter  int NUM_LINES = 4,
  localparam int IDX_W     = index_width(NUM_LINES),
  localparam int TAG_W     = tag_width(WORD_SIZE, NUM_LINES),
  localparam int LINE_W    = LINE_WORDS * WORD_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_W-1:0]       rd_index,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [LINE_W-1:0]      rd_line,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_index,
  input  logic [OFFSET_BITS-1:0] wr_offset,
  input  logic [WORD_SIZE-1:0]   wr_data,
  input  logic                   fill_en,
  input  logic [IDX_W-1:0]       fill_index,
  input  logic [TAG_W-1:0]       fill_tag,
  input  logic [LINE_W-1:0]      fill_line,
  input  logic                   clean_en,
  input  logic [IDX_W-1:0]       clean_index
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [LINE_W-1:0]    data_d [NUM_LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  // Next-state of the storage: a fill overrides everything, then word write, then clean.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[fill_index] = 1'b1;
      dirty_d[fill_index] = 1'b0;
      tag_d[fill_index]   = fill_tag;
      data_d[fill_index]  = fill_line;
    end else if (wr_en) begin
      data_d[wr_index][wr_offset*WORD_SIZE +: WORD_SIZE] = wr_data;
      dirty_d[wr_index] = 1'b1;
    end else if (clean_en) begin
      dirty_d[clean_index] = 1'b0;
    end else begin
      dirty_d = dirty_q;
    end
  end

  // Storage registers; reset invalidates every line and drops any dirty data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller: single-word cpu
// accesses in, line-wide memory fills/write-backs out, plus hit/access counters.
module dm_cache_ctrl
  import cache_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_LINES  = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpu_read,
  input  logic                             cpu_write,
  input  logic [WORD_SIZE-1:0]             cpu_address,
  input  logic [WORD_SIZE-1:0]             cpu_wdata,
  output logic [WORD_SIZE-1:0]             cpu_rdata,
  output logic                             cpu_ready,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [WORD_SIZE-1:0]             mem_address,
  output logic [LINE_WORDS*WORD_SIZE-1:0]  mem_wdata,
  input  logic [LINE_WORDS*WORD_SIZE-1:0]  mem_rdata,
  input  logic                             mem_ack,
  output logic [WORD_SIZE-1:0]             hit_count,
  output logic [WORD_SIZE-1:0]             access_count
);

  localparam int IDX_W  = index_width(NUM_LINES);
  localparam int TAG_W  = tag_width(WORD_SIZE, NUM_LINES);
  localparam int LINE_W = LINE_WORDS * WORD_SIZE;
  localparam logic [WORD_SIZE-1:0] CNT_MAX = '1;

  cache_state_e            state_q, state_d;
  logic                    miss_flag_q, miss_flag_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [WORD_SIZE-1:0]    mem_address_q, mem_address_d;
  logic [LINE_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic [IDX_W-1:0]        miss_index_q, miss_index_d;
  logic [TAG_W-1:0]        miss_tag_q, miss_tag_d;
  logic [WORD_SIZE-1:0]    hit_count_q, hit_count_d;
  logic [WORD_SIZE-1:0]    access_count_q, access_count_d;

  logic                    req_s;
  logic                    hit_s;
  logic [OFFSET_BITS-1:0]  req_offset_s;
  logic [IDX_W-1:0]        req_index_s;
  logic [TAG_W-1:0]        req_tag_s;
  logic                    rd_valid_s;
  logic                    rd_dirty_s;
  logic [TAG_W-1:0]        rd_tag_s;
  logic [LINE_W-1:0]       rd_line_s;

  assign req_s        = cpu_read | cpu_write;
  assign req_offset_s = cpu_address[OFFSET_BITS-1:0];
  assign req_index_s  = cpu_address[OFFSET_BITS +: IDX_W];
  assign req_tag_s    = cpu_address[WORD_SIZE-1 -: TAG_W];

  assign hit_s     = (state_q == IDLE) & req_s & rd_valid_s & (rd_tag_s == req_tag_s);
  assign cpu_ready = hit_s;
  assign cpu_rdata = hit_s ? rd_line_s[req_offset_s*WORD_SIZE +: WORD_SIZE] : '0;

  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_address  = mem_address_q;
  assign mem_wdata    = mem_wdata_q;
  assign hit_count    = hit_count_q;
  assign access_count = access_count_q;

  // Fill and clean use the latched miss index so a dropped request cannot redirect them.
  cache_line_array #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_LINES (NUM_LINES)
  ) u_lines (
    .clk         (clk),
    .rst         (reset),
    .rd_index    (req_index_s),
    .rd_valid    (rd_valid_s),
    .rd_dirty    (rd_dirty_s),
    .rd_tag      (rd_tag_s),
    .rd_line     (rd_line_s),
    .wr_en       (hit_s & cpu_write),
    .wr_index    (req_index_s),
    .wr_offset   (req_offset_s),
    .wr_data     (cpu_wdata),
    .fill_en     ((state_q == FILL) & mem_ack),
    .fill_index  (miss_index_q),
    .fill_tag    (miss_tag_q),
    .fill_line   (mem_rdata),
    .clean_en    ((state_q == WRITEBACK) & mem_ack),
    .clean_index (miss_index_q)
  );

  // Miss handling FSM, memory strobes and the saturating counters.
  always_comb begin
    state_d        = state_q;
    miss_flag_d    = miss_flag_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    mem_address_d  = mem_address_q;
    mem_wdata_d    = mem_wdata_q;
    miss_index_d   = miss_index_q;
    miss_tag_d     = miss_tag_q;
    hit_count_d    = hit_count_q;
    access_count_d = access_count_q;

    case (state_q)
      IDLE: begin
        if (req_s && !hit_s) begin
          miss_flag_d  = 1'b1;
          miss_index_d = req_index_s;
          miss_tag_d   = req_tag_s;
          mem_wdata_d  = rd_line_s;
          if (rd_valid_s && rd_dirty_s) begin
            state_d       = WRITEBACK;
            mem_write_d   = 1'b1;
            mem_address_d = {rd_tag_s, req_index_s, 2'b00};
          end else begin
            state_d       = FILL;
            mem_read_d    = 1'b1;
            mem_address_d = {req_tag_s, req_index_s, 2'b00};
          end
        end else if (hit_s) begin
          miss_flag_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      WRITEBACK: begin
        if (mem_ack) begin
          state_d       = FILL;
          mem_write_d   = 1'b0;
          mem_read_d    = 1'b1;
          mem_address_d = {miss_tag_q, miss_index_q, 2'b00};
        end else begin
          state_d = WRITEBACK;
        end
      end
      FILL: begin
        if (mem_ack) begin
          state_d       = IDLE;
          mem_read_d    = 1'b0;
          mem_address_d = '0;
        end else begin
          state_d = FILL;
        end
      end
      default: begin
        state_d       = IDLE;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_address_d = '0;
      end
    endcase

    if (hit_s) begin
      if (access_count_q != CNT_MAX) begin
        access_count_d = access_count_q + {{(WORD_SIZE-1){1'b0}}, 1'b1};
      end else begin
        access_count_d = access_count_q;
      end
      if (!miss_flag_q && (hit_count_q != CNT_MAX)) begin
        hit_count_d = hit_count_q + {{(WORD_SIZE-1){1'b0}}, 1'b1};
      end else begin
        hit_count_d = hit_count_q;
      end
    end else begin
      access_count_d = access_count_q;
    end
  end

  // Controller registers; reset aborts any transaction and drops strobes at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      miss_flag_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_address_q  <= '0;
      mem_wdata_q    <= '0;
      miss_index_q   <= '0;
      miss_tag_q     <= '0;
      hit_count_q    <= '0;
      access_count_q <= '0;
    end else begin
      state_q        <= state_d;
      miss_flag_q    <= miss_flag_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_address_q  <= mem_address_d;
      mem_wdata_q    <= mem_wdata_d;
      miss_index_q   <= miss_index_d;
      miss_tag_q     <= miss_tag_d;
      hit_count_q    <= hit_count_d;
      access_count_q <= access_count_d;
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed self-checking bench for dm_cache_ctrl with a small line-based memory responder.
module tb_dm_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [15:0] cpu_address = 16'h0000;
  logic [15:0] cpu_wdata = 16'h0000;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = 64'h0;
  logic        mem_ack = 1'b0;
  logic [15:0] hit_count;
  logic [15:0] access_count;

  always #5 clk = ~clk;

  dm_cache_ctrl #(.WORD_SIZE(16), .NUM_LINES(4), .LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_count(hit_count), .access_count(access_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory model and transaction log
  logic [15:0] mem_model [0:255];
  int          wait_cnt = 0;
  int          wb_count = 0;
  int          fill_count = 0;
  logic [15:0] last_wb_addr = 16'h0;
  logic [63:0] last_wb_data = 64'h0;
  logic [15:0] last_fill_addr = 16'h0;
  logic        both_high = 1'b0;
  logic [7:0]  ev_seq = 8'h0;
  logic [7:0]  ma;

  initial begin
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) both_high = 1'b1;
      if (reset) begin
        wait_cnt = 0;
        mem_ack = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_read || mem_write) begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          wait_cnt = 0;
          mem_ack = 1'b1;
          ma = mem_address[7:0];
          if (mem_write) begin
            wb_count++;
            last_wb_addr = mem_address;
            last_wb_data = mem_wdata;
            mem_model[ma]        = mem_wdata[15:0];
            mem_model[ma + 8'd1] = mem_wdata[31:16];
            mem_model[ma + 8'd2] = mem_wdata[47:32];
            mem_model[ma + 8'd3] = mem_wdata[63:48];
            ev_seq = {ev_seq[5:0], 2'b01};
          end else begin
            fill_count++;
            last_fill_addr = mem_address;
            mem_rdata = {mem_model[ma + 8'd3], mem_model[ma + 8'd2],
                         mem_model[ma + 8'd1], mem_model[ma]};
            ev_seq = {ev_seq[5:0], 2'b10};
          end
        end
      end
    end
  end

  task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wd, output logic [15:0] rdata,
                           output int cycles);
    @(negedge clk);
    cpu_read = rd;
    cpu_write = wr;
    cpu_address = addr;
    cpu_wdata = wd;
    cycles = 0;
    #1;
    while (!cpu_ready && cycles < 60) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    check_eq("ready_within_budget", {63'd0, cpu_ready}, 64'd1);
    rdata = cpu_rdata;
    @(posedge clk);
    #1;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  logic [15:0] rd;
  int          cyc;
  int          fc0;

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 16'h0100 + 16'(i);
    mem_model[16] = 16'h000A;
    mem_model[17] = 16'h000B;
    mem_model[18] = 16'h000C;
    mem_model[19] = 16'h000D;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", {63'd0, cpu_ready}, 64'd0);
    check_eq("rst_mem_read", {63'd0, mem_read}, 64'd0);
    check_eq("rst_mem_write", {63'd0, mem_write}, 64'd0);
    check_eq("rst_mem_addr", {48'd0, mem_address}, 64'd0);
    check_eq("rst_rdata", {48'd0, cpu_rdata}, 64'd0);
    check_eq("rst_hits", {48'd0, hit_count}, 64'd0);
    check_eq("rst_accesses", {48'd0, access_count}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // cold read miss
    do_access(1'b1, 1'b0, 16'h0012, 16'h0000, rd, cyc);
    check_eq("cold_rdata", {48'd0, rd}, 64'h000C);
    check_eq("cold_was_stalled", {63'd0, cyc > 0}, 64'd1);
    check_eq("cold_fill_addr", {48'd0, last_fill_addr}, 64'h0010);
    check_eq("cold_fill_cnt", 64'(fill_count), 64'd1);
    check_eq("cold_hits", {48'd0, hit_count}, 64'd0);
    check_eq("cold_accesses", {48'd0, access_count}, 64'd1);

    // read hit, same line
    do_access(1'b1, 1'b0, 16'h0013, 16'h0000, rd, cyc);
    check_eq("hit_rdata", {48'd0, rd}, 64'h000D);
    check_eq("hit_same_cycle", 64'(cyc), 64'd0);
    check_eq("hit_no_fill", 64'(fill_count), 64'd1);
    check_eq("hit_hits", {48'd0, hit_count}, 64'd1);
    check_eq("hit_accesses", {48'd0, access_count}, 64'd2);

    // write hit, then conflicting read forces write-back before fill
    do_access(1'b0, 1'b1, 16'h0011, 16'h1234, rd, cyc);
    check_eq("whit_same_cycle", 64'(cyc), 64'd0);
    check_eq("whit_no_wb", 64'(wb_count), 64'd0);
    do_access(1'b1, 1'b0, 16'h0050, 16'h0000, rd, cyc);
    check_eq("conf_wb_addr", {48'd0, last_wb_addr}, 64'h0010);
    check_eq("conf_wb_data", last_wb_data, 64'h000D_000C_1234_000A);
    check_eq("conf_fill_addr", {48'd0, last_fill_addr}, 64'h0050);
    check_eq("conf_order", {60'd0, ev_seq[3:0]}, 64'h6);
    check_eq("conf_rdata", {48'd0, rd}, 64'h0150);
    check_eq("conf_hits", {48'd0, hit_count}, 64'd2);
    check_eq("conf_accesses", {48'd0, access_count}, 64'd4);

    // write miss with clean victim, then re-read and evict via conflict
    do_access(1'b1, 1'b1, 16'h0024, 16'hBEEF, rd, cyc);
    check_eq("wmiss_fill_addr", {48'd0, last_fill_addr}, 64'h0024);
    check_eq("wmiss_no_wb", 64'(wb_count), 64'd1);
    do_access(1'b1, 1'b0, 16'h0024, 16'h0000, rd, cyc);
    check_eq("wmiss_merged", {48'd0, rd}, 64'h BEEF);
    check_eq("wmiss_hit_cycle", 64'(cyc), 64'd0);
    do_access(1'b1, 1'b0, 16'h0064, 16'h0000, rd, cyc);
    check_eq("evict_wb_addr", {48'd0, last_wb_addr}, 64'h0024);
    check_eq("evict_wb_data", last_wb_data, 64'h0127_0126_0125_BEEF);
    check_eq("evict_mem_word", {48'd0, mem_model[8'h24]}, 64'h BEEF);
    check_eq("evict_rdata", {48'd0, rd}, 64'h0164);
    check_eq("evict_hits", {48'd0, hit_count}, 64'd3);
    check_eq("evict_accesses", {48'd0, access_count}, 64'd7);
    check_eq("never_both_strobes", {63'd0, both_high}, 64'd0);

    // reset in the middle of a fill
    @(negedge clk);
    cpu_read = 1'b1;
    cpu_address = 16'h0011;
    cyc = 0;
    while (!mem_read && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("midrst_fill_seen", {63'd0, mem_read}, 64'd1);
    reset = 1'b1;
    #1;
    check_eq("midrst_mem_read", {63'd0, mem_read}, 64'd0);
    check_eq("midrst_ready", {63'd0, cpu_ready}, 64'd0);
    check_eq("midrst_mem_addr", {48'd0, mem_address}, 64'd0);
    check_eq("midrst_hits", {48'd0, hit_count}, 64'd0);
    check_eq("midrst_accesses", {48'd0, access_count}, 64'd0);
    cpu_read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fc0 = fill_count;
    do_access(1'b1, 1'b0, 16'h0011, 16'h0000, rd, cyc);
    check_eq("postrst_miss_again", 64'(fill_count), 64'(fc0 + 1));
    check_eq("postrst_fill_addr", {48'd0, last_fill_addr}, 64'h0010);
    check_eq("postrst_rdata", {48'd0, rd}, 64'h1234);
    check_eq("postrst_hits", {48'd0, hit_count}, 64'd0);
    check_eq("postrst_accesses", {48'd0, access_count}, 64'd1);

    // saturation: hold a hitting read for more than 2^16 cycles
    @(negedge clk);
    cpu_read = 1'b1;
    cpu_address = 16'h0011;
    repeat (65540) @(posedge clk);
    #1;
    check_eq("sat_accesses", {48'd0, access_count}, 64'hFFFF);
    check_eq("sat_hits", {48'd0, hit_count}, 64'hFFFF);
    cpu_read = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
